dcache_inv_sequencer: RTL

Sequences whole-cache invalidation of the data cache tag banks and arbitrates the single tag-bank invalidate port between the flush sweep and external single-line invalidations. Sits beside the data cache: it drives the tag banks' invalidate address/valid inputs, and it gates new load/store requests into the cache while a flush is in progress. It is used for fence-style flushes and for cache-enable transitions.

---
 rtl/dcache_inv_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dcache_inv_sequencer.sv
// Data-cache invalidation sequencer: whole-cache tag sweep plus arbitration of the
// single tag-bank invalidate port. Define DCACHE_INV_SEQ_STATS_EN to add flush_cycles.
module dcache_inv_sequencer #(
   parameter int unsigned LINES  = 64,
   parameter int unsigned LINE_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_req,
   output logic        flush_ack,
   input  logic        ls_idle,
   output logic        ls_block,
   input  logic        ext_inv_valid,
   input  logic [29:0] ext_inv_addr,
   output logic        ext_inv_ack,
   output logic        inv_valid,
   output logic [29:0] inv_addr,
   output logic        busy
`ifdef DCACHE_INV_SEQ_STATS_EN
   ,
   output logic [15:0] flush_cycles
`endif
);

   localparam int unsigned LINE_ADDR_W     = $clog2(LINES);
   localparam int unsigned SUB_LINE_ADDR_W = $clog2(LINE_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [LINE_ADDR_W-1:0] r_idx;
   logic [LINE_ADDR_W-1:0] w_idx_nxt;
   logic                   r_pending;
   logic                   w_pending_nxt;
   logic                   r_ls_block;
   logic                   w_sweep_issue;
   logic                   w_idx_last;
   logic [29:0]            w_sweep_addr;

   assign w_idx_last   = (r_idx == LINE_ADDR_W'(LINES - 1));
   assign w_sweep_addr = 30'(r_idx) << SUB_LINE_ADDR_W;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_pending_nxt = r_pending;
      w_sweep_issue = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (flush_req) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (flush_req) w_pending_nxt = 1'b1;
            if (ls_idle) begin
               w_state_nxt = S_SWEEP;
               w_idx_nxt   = '0;
            end
         end
         S_SWEEP: begin
            if (flush_req) w_pending_nxt = 1'b1;
            // External invalidations own the port; the sweep stalls on the same index.
            if (!ext_inv_valid) begin
               w_sweep_issue = 1'b1;
               if (w_idx_last) w_state_nxt = S_DONE;
               else            w_idx_nxt   = r_idx + LINE_ADDR_W'(1);
            end
         end
         S_DONE: begin
            // A request arriving in DONE folds into the restart like an earlier pending one.
            w_pending_nxt = 1'b0;
            w_state_nxt   = (r_pending || flush_req) ? S_DRAIN : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_pending  <= 1'b0;
         r_ls_block <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_pending  <= w_pending_nxt;
         r_ls_block <= (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      inv_valid   = ext_inv_valid | w_sweep_issue;
      inv_addr    = '0;
      if (ext_inv_valid)      inv_addr = ext_inv_addr;
      else if (w_sweep_issue) inv_addr = w_sweep_addr;
      ext_inv_ack = ext_inv_valid;
      flush_ack   = (r_state == S_DONE);
      busy        = (r_state != S_IDLE);
      ls_block    = r_ls_block;
   end

`ifdef DCACHE_INV_SEQ_STATS_EN
   logic [15:0] r_cyc;
   logic [15:0] r_flush_cycles;

   // r_cyc holds the 1-based cycle number within the current flush, DRAIN entry being 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cyc          <= '0;
         r_flush_cycles <= '0;
      end else begin
         if (w_state_nxt == S_DRAIN && r_state != S_DRAIN) r_cyc <= 16'd1;
         else if (r_state != S_IDLE && r_cyc != '1)        r_cyc <= r_cyc + 16'd1;
         if (r_state == S_DONE) r_flush_cycles <= r_cyc;
      end
   end

   assign flush_cycles = r_flush_cycles;
`endif

endmodule
